// File: rtl/dc_lookup_ctrl.sv
// dc_lookup_ctrl: sequences one READ/WRITE/FILL line request at a time
// against the direct-mapped DRAM-cache tag/data store over AXI-style
// channels. It reports hit/miss with victim information and keeps
// saturating hit/miss statistics.
module dc_lookup_ctrl #(
    parameter logic [15:0] AXI_ID = 16'd1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [63:0]        req_addr,
    input  logic [511:0]       req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hit,
    output logic [511:0]       resp_rdata,
    output logic               resp_victim_valid,
    output logic               resp_victim_dirty,
    output logic [63:0]        resp_victim_addr,
    output logic [15:0]        arid_o,
    output logic [63:0]        araddr_o,
    output logic               arvalid_o,
    input  logic               arready_i,
    input  logic [15:0]        rid_i,
    input  logic [575:0]       rdata_i,
    input  logic               rvalid_i,
    output logic               rready_o,
    output logic [15:0]        awid_o,
    output logic [63:0]        awaddr_o,
    output logic               awvalid_o,
    input  logic               awready_i,
    output logic [15:0]        wid_o,
    output logic [511:0]       wdata_o,
    output logic               wvalid_o,
    input  logic               wready_i,
    input  logic [15:0]        bid_i,
    input  logic               bvalid_i,
    output logic               bready_o,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    typedef enum logic [2:0] {IDLE, AR, R, CMP, WR, B, RESP} state_t;
    typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_FILL = 2'd2} op_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t         state;
    state_t         state_next;
    op_t            op_q;
    op_t            op_in;
    logic [63:0]    addr_q;
    logic [511:0]   wdata_q;
    logic [575:0]   line_q;
    logic           aw_done;
    logic           w_done;
    logic           aw_hs;
    logic           w_hs;
    logic           wr_finish;
    logic [63:0]    tag_word;
    logic           tag_hit;
    logic           hit_q;
    logic           vvalid_q;
    logic           vdirty_q;
    logic [63:0]    vaddr_q;
    logic           unused_bits;

    assign arid_o = AXI_ID;
    assign awid_o = AXI_ID;
    assign wid_o  = AXI_ID;

    assign tag_word  = line_q[575:512];
    assign tag_hit   = tag_word[63] && (tag_word[61:30] == {1'b0, addr_q[62:32]});
    assign aw_hs     = awvalid_o && awready_i;
    assign w_hs      = wvalid_o && wready_i;
    assign wr_finish = (aw_done || aw_hs) && (w_done || w_hs);

    assign unused_bits = ^{rid_i, bid_i, addr_q[5:0], tag_word[29:0]};

    // Reserved opcode behaves as READ, so it is folded away at the input.
    always_comb begin
        case (req_op)
            2'd1:    op_in = OP_WRITE;
            2'd2:    op_in = OP_FILL;
            default: op_in = OP_READ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and channel/response outputs.
    always_comb begin
        state_next        = state;
        req_ready         = 1'b0;
        arvalid_o         = 1'b0;
        araddr_o          = '0;
        rready_o          = 1'b0;
        awvalid_o         = 1'b0;
        awaddr_o          = '0;
        wvalid_o          = 1'b0;
        wdata_o           = '0;
        bready_o          = 1'b0;
        resp_valid        = 1'b0;
        resp_hit          = 1'b0;
        resp_rdata        = '0;
        resp_victim_valid = 1'b0;
        resp_victim_dirty = 1'b0;
        resp_victim_addr  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (op_in == OP_FILL) ? WR : AR;
            end
            AR: begin
                arvalid_o = 1'b1;
                araddr_o  = {addr_q[63:6], 6'b0};
                if (arready_i) state_next = R;
            end
            R: begin
                rready_o = 1'b1;
                if (rvalid_i) state_next = CMP;
            end
            CMP: begin
                state_next = (op_q == OP_WRITE && tag_hit) ? WR : RESP;
            end
            WR: begin
                awvalid_o = !aw_done;
                wvalid_o  = !w_done;
                // Address bit 63 carries the dirty flag to the store.
                awaddr_o  = {(op_q != OP_FILL), addr_q[62:6], 6'b0};
                wdata_o   = wdata_q;
                if (wr_finish) state_next = B;
            end
            B: begin
                bready_o = 1'b1;
                if (bvalid_i) state_next = RESP;
            end
            RESP: begin
                resp_valid        = 1'b1;
                resp_hit          = hit_q;
                resp_rdata        = (op_q == OP_FILL) ? wdata_q : line_q[511:0];
                resp_victim_valid = vvalid_q;
                resp_victim_dirty = vdirty_q;
                resp_victim_addr  = vaddr_q;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and line buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q    <= op_in;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == R && rvalid_i) line_q <= rdata_i;
        end
    end

    // Registered compare result; cleared on accept so FILL reports zeros.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && req_valid)) begin
            hit_q    <= 1'b0;
            vvalid_q <= 1'b0;
            vdirty_q <= 1'b0;
            vaddr_q  <= '0;
        end else if (state == CMP) begin
            hit_q    <= tag_hit;
            vvalid_q <= !tag_hit && tag_word[63];
            vdirty_q <= !tag_hit && tag_word[62];
            vaddr_q  <= {1'b0, tag_word[60:30], addr_q[31:6], 6'b0};
        end
    end

    // AW and W complete independently; each valid drops after its own handshake.
    always_ff @(posedge clk) begin
        if (rst || state != WR || wr_finish) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Saturating hit/miss statistics for READ and WRITE lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == CMP) begin
            if (tag_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_ONE;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_dc_lookup_ctrl.sv
// tb_dc_lookup_ctrl: drives dc_lookup_ctrl against a behavioural tag/data
// store and checks responses, store contents and counters against a
// reference cache model kept in plain arrays.
module tb_dc_lookup_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = '0;
    logic [63:0]    req_addr = '0;
    logic [511:0]   req_wdata = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic           resp_hit;
    logic [511:0]   resp_rdata;
    logic           resp_victim_valid;
    logic           resp_victim_dirty;
    logic [63:0]    resp_victim_addr;
    logic [15:0]    arid_o;
    logic [63:0]    araddr_o;
    logic           arvalid_o;
    logic           arready_i = 1'b0;
    logic [15:0]    rid_i = 16'd1;
    logic [575:0]   rdata_i = '0;
    logic           rvalid_i = 1'b0;
    logic           rready_o;
    logic [15:0]    awid_o;
    logic [63:0]    awaddr_o;
    logic           awvalid_o;
    logic           awready_i = 1'b0;
    logic [15:0]    wid_o;
    logic [511:0]   wdata_o;
    logic           wvalid_o;
    logic           wready_i = 1'b0;
    logic [15:0]    bid_i = 16'd1;
    logic           bvalid_i = 1'b0;
    logic           bready_o;
    logic [31:0]    hit_cnt;
    logic [31:0]    miss_cnt;

    dc_lookup_ctrl #(.AXI_ID(16'd1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_rdata(resp_rdata), .resp_victim_valid(resp_victim_valid),
        .resp_victim_dirty(resp_victim_dirty), .resp_victim_addr(resp_victim_addr),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Store contents (written only through the DUT) and the reference model.
    logic [63:0]  st_tag   [int unsigned];
    logic [511:0] st_data  [int unsigned];
    logic [63:0]  ref_tag  [int unsigned];
    logic [511:0] ref_data [int unsigned];

    function automatic logic [63:0] st_tag_rd(input int unsigned i);
        return st_tag.exists(i) ? st_tag[i] : 64'd0;
    endfunction
    function automatic logic [511:0] st_data_rd(input int unsigned i);
        return st_data.exists(i) ? st_data[i] : 512'd0;
    endfunction
    function automatic logic [63:0] ref_tag_rd(input int unsigned i);
        return ref_tag.exists(i) ? ref_tag[i] : 64'd0;
    endfunction
    function automatic logic [511:0] ref_data_rd(input int unsigned i);
        return ref_data.exists(i) ? ref_data[i] : 512'd0;
    endfunction

    // mode: 0 always ready, 1 random, 2 AW ready now / W ready later, 3 write readies held low
    int mode = 0;
    int n_ar = 0, n_aw = 0, n_w = 0, viol = 0;
    logic [63:0]  last_awaddr = '0;
    int unsigned  r_idx;
    int           r_wait, b_wait, wseen;
    logic         r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    logic         ar_h, r_h, aw_h, w_h, b_h;
    logic [63:0]  aw_a;
    logic [511:0] w_d;

    // Behavioural store: samples handshakes at the edge, drives responses #1 later.
    always @(posedge clk) begin
        ar_h = arvalid_o && arready_i;
        r_h  = rvalid_i && rready_o;
        aw_h = awvalid_o && awready_i;
        w_h  = wvalid_o && wready_i;
        b_h  = bvalid_i && bready_o;
        if (rst) begin
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; wseen = 0;
        end else begin
            if (ar_h) begin
                n_ar++;
                r_pend = 1;
                r_idx  = int'(araddr_o[31:6]);
                r_wait = (mode == 1) ? int'($urandom_range(0, 3)) : 1;
            end
            if (aw_h) begin n_aw++; aw_got = 1; aw_a = awaddr_o; last_awaddr = awaddr_o; end
            if (w_h) begin n_w++; w_got = 1; w_d = wdata_o; wseen = 0; end
            else if (wvalid_o) wseen++;
            if (aw_got && w_got) begin
                st_tag[int'(aw_a[31:6])]  = {1'b1, aw_a[63], 1'b0, aw_a[62:32], 30'd0};
                st_data[int'(aw_a[31:6])] = w_d;
                aw_got = 0; w_got = 0;
                b_pend = 1;
                b_wait = (mode == 1) ? int'($urandom_range(0, 3)) : 2;
            end
        end
        #1;
        if (rst) begin
            arready_i = 0; rvalid_i = 0; rdata_i = '0; awready_i = 0; wready_i = 0; bvalid_i = 0;
        end else begin
            if (r_h) rvalid_i = 0;
            if (b_h) bvalid_i = 0;
            if (r_pend) begin
                if (r_wait <= 0) begin
                    rvalid_i = 1; rdata_i = {st_tag_rd(r_idx), st_data_rd(r_idx)}; r_pend = 0;
                end else r_wait--;
            end
            if (b_pend) begin
                if (b_wait <= 0) begin bvalid_i = 1; b_pend = 0; end
                else b_wait--;
            end
            case (mode)
                1: begin
                    arready_i = 1'($urandom_range(0, 1));
                    awready_i = 1'($urandom_range(0, 1));
                    wready_i  = 1'($urandom_range(0, 1));
                end
                2: begin arready_i = 1; awready_i = 1; wready_i = (wseen >= 3); end
                3: begin arready_i = 1; awready_i = 0; wready_i = 0; end
                default: begin arready_i = 1; awready_i = 1; wready_i = 1; end
            endcase
        end
    end

    // Read and write channels must never be active together.
    always @(negedge clk) begin
        if (!rst && (arvalid_o || rready_o) && (awvalid_o || wvalid_o || bready_o)) viol++;
    end

    int exp_hits = 0, exp_miss = 0;

    task automatic do_req(input logic [1:0] op, input logic [63:0] addr, input logic [511:0] wd,
                          input int stall, input int exp_lat);
        int unsigned idx;
        logic [63:0]  t;
        logic [511:0] d, e_rd, c_rd;
        logic         e_hit, e_vv, e_vd, c_hit, c_vv, c_vd, stable;
        logic [63:0]  e_va, c_va;
        int           e_ar, e_aw, cyc;
        idx = int'(addr[31:6]);
        t = ref_tag_rd(idx);
        d = ref_data_rd(idx);
        e_hit = 0; e_vv = 0; e_vd = 0; e_va = '0; e_ar = 0; e_aw = 0; e_rd = d;
        if (op == 2'd2) begin
            e_rd = wd; e_aw = 1;
            ref_tag[idx]  = {1'b1, 1'b0, 1'b0, addr[62:32], 30'd0};
            ref_data[idx] = wd;
        end else begin
            e_ar  = 1;
            e_hit = t[63] && (t[61:30] == {1'b0, addr[62:32]});
            if (e_hit) exp_hits++;
            else begin
                exp_miss++;
                e_vv = t[63]; e_vd = t[62];
                e_va = {1'b0, t[60:30], addr[31:6], 6'd0};
            end
            if (op == 2'd1 && e_hit) begin
                e_aw = 1;
                ref_tag[idx]  = {1'b1, 1'b1, 1'b0, addr[62:32], 30'd0};
                ref_data[idx] = wd;
            end
        end
        @(negedge clk);
        n_ar = 0; n_aw = 0; n_w = 0;
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!req_ready) check_val("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        cyc = 1;
        while (!resp_valid && cyc < 200) begin @(negedge clk); cyc++; end
        if (!resp_valid) check_val("resp_timeout", 0, 1);
        if (exp_lat >= 0) check_val("latency", cyc, exp_lat);
        c_hit = resp_hit; c_rd = resp_rdata; c_vv = resp_victim_valid;
        c_vd = resp_victim_dirty; c_va = resp_victim_addr;
        stable = 1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (resp_hit !== c_hit || resp_rdata !== c_rd || resp_victim_valid !== c_vv ||
                resp_victim_dirty !== c_vd || resp_victim_addr !== c_va || resp_valid !== 1'b1 ||
                req_ready !== 1'b0 || arvalid_o || rready_o || awvalid_o || wvalid_o || bready_o)
                stable = 0;
        end
        if (stall > 0) check_val("stall_stable", stable, 1);
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        check_val("resp_hit", c_hit, e_hit);
        check_val("resp_rdata", c_rd, e_rd);
        check_val("victim_valid", c_vv, e_vv);
        check_val("victim_dirty", c_vd, e_vd);
        if (op == 2'd2 || !e_hit) check_val("victim_addr", c_va, e_va);
        check_val("hit_cnt", hit_cnt, exp_hits);
        check_val("miss_cnt", miss_cnt, exp_miss);
        check_val("ar_count", n_ar, e_ar);
        check_val("aw_count", n_aw, e_aw);
        check_val("w_count", n_w, e_aw);
        check_val("store_tag", st_tag_rd(idx), ref_tag_rd(idx));
        check_val("store_data", st_data_rd(idx), ref_data_rd(idx));
        check_val("idle_ready", req_ready, 1);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int          cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_valids", {resp_valid, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
        check_val("rst_resp", {resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_addr, resp_rdata}, 0);
        check_val("rst_cnt", {hit_cnt, miss_cnt}, 0);
        rst = 0;

        do_req(2'd0, 64'h0000_0000_0000_0040, '0, 0, 5);
        do_req(2'd2, 64'h0000_0005_0000_0080, {64{8'hA5}}, 0, -1);
        check_val("fill_tag_word", st_tag_rd(2), 64'h8000_0001_4000_0000);
        do_req(2'd0, 64'h0000_0005_0000_0080, '0, 0, 5);
        check_val("hit_read_cnt", hit_cnt, 1);
        do_req(2'd1, 64'h0000_0005_0000_0080, {64{8'h3C}}, 0, 9);
        check_val("wr_awaddr", last_awaddr, 64'h8000_0005_0000_0080);
        check_val("wr_tag_word", st_tag_rd(2), 64'hC000_0001_4000_0000);
        do_req(2'd0, 64'h0000_0005_0000_0080, '0, 0, -1);
        do_req(2'd0, 64'h0000_0007_0000_0080, '0, 10, -1);
        mode = 2;
        do_req(2'd1, 64'h0000_0005_0000_0080, {64{8'h11}}, 0, -1);
        do_req(2'd3, 64'h0000_0005_0000_0080, '0, 0, -1);

        mode = 1;
        for (int n = 0; n < 150; n++) begin
            a = '0;
            a[62:32] = ($urandom_range(0, 4) == 4) ? 31'h4000_0003 : 31'($urandom_range(0, 3));
            a[31:6]  = ($urandom_range(0, 5) == 5) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
            a[5:0]   = 6'($urandom);
            do_req(2'($urandom_range(0, 3)), a, rnd512(), int'($urandom_range(0, 2)), -1);
        end

        // Reset while the write phase is stalled.
        mode = 3;
        @(negedge clk);
        req_valid = 1; req_op = 2'd2; req_addr = 64'h0000_0003_0000_0100; req_wdata = rnd512();
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        cyc = 0;
        while (!awvalid_o && cyc < 50) begin @(negedge clk); cyc++; end
        check_val("wr_reached", awvalid_o, 1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_valids", {resp_valid, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
        check_val("midrst_req_ready", req_ready, 1);
        check_val("midrst_cnt", {hit_cnt, miss_cnt}, 0);
        rst = 0;
        st_tag.delete(); st_data.delete(); ref_tag.delete(); ref_data.delete();
        exp_hits = 0; exp_miss = 0;
        mode = 0;
        do_req(2'd0, 64'h0000_0000_0000_0040, '0, 0, 5);

        check_val("axi_exclusive", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
